branch_predict_unit: RTL



---
 rtl/branch_predict_unit_pkg.sv | 45 ++++
 rtl/branch_predict_unit_if.sv | 37 +++
 rtl/branch_predict_unit_table.sv | 70 +++++++
 rtl/branch_predict_unit.sv | 93 +++++++++
 4 files changed

// File: rtl/branch_predict_unit_pkg.sv
// Shared encodings and types for the branch predict unit: brsel codes, counter
// type and helpers, and the per-entry BTB metadata.
package bpu_pkg;

    localparam logic [3:0] BR_NONE = 4'b0000;
    localparam logic [3:0] BR_JAL  = 4'b1000;
    localparam logic [3:0] BR_JALR = 4'b1001;

    typedef logic [1:0] ctr_t;

    localparam ctr_t CTR_RESET       = 2'b01;
    localparam ctr_t CTR_TAKEN_ALLOC = 2'b10;
    localparam ctr_t CTR_JUMP        = 2'b11;

    typedef enum logic [1:0] {
        CL_NONE,
        CL_COND,
        CL_JAL,
        CL_JALR
    } brclass_e;

    // Tag and target widths depend on module parameters, so they live beside
    // this struct in the table rather than inside it.
    typedef struct packed {
        logic valid;
        ctr_t ctr;
    } btb_entry_t;

    // Undefined 1xxx codes behave like NONE.
    function automatic brclass_e classify(input logic [3:0] brsel);
        if (brsel == BR_JAL)                        return CL_JAL;
        else if (brsel == BR_JALR)                  return CL_JALR;
        else if (!brsel[3] && brsel[2:0] != 3'b000) return CL_COND;
        else                                        return CL_NONE;
    endfunction

    function automatic ctr_t ctr_inc(input ctr_t c);
        return (c == 2'b11) ? c : c + 2'b01;
    endfunction

    function automatic ctr_t ctr_dec(input ctr_t c);
        return (c == 2'b00) ? c : c - 2'b01;
    endfunction

endpackage

// File: rtl/branch_predict_unit_if.sv
// Fetch-predict, EX-resolve and statistics signals between the pipeline
// (master) and the branch predict unit (slave).
interface bpu_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
);
    logic [XLEN-1:0]  if_pc;
    logic             pred_taken;
    logic [XLEN-1:0]  pred_target;
    logic             ex_valid;
    logic [XLEN-1:0]  ex_pc;
    logic [3:0]       ex_brsel;
    logic [XLEN-1:0]  ex_immediate;
    logic [XLEN-1:0]  ex_rs1;
    logic             ex_cond;
    logic             ex_pred_taken;
    logic [XLEN-1:0]  ex_pred_target;
    logic             has_branched;
    logic             mispredict;
    logic [XLEN-1:0]  redirect_pc;
    logic [CNT_W-1:0] stat_branches;
    logic [CNT_W-1:0] stat_mispred;

    modport master (
        output if_pc, ex_valid, ex_pc, ex_brsel, ex_immediate, ex_rs1,
               ex_cond, ex_pred_taken, ex_pred_target,
        input  pred_taken, pred_target, has_branched, mispredict, redirect_pc,
               stat_branches, stat_mispred
    );

    modport slave (
        input  if_pc, ex_valid, ex_pc, ex_brsel, ex_immediate, ex_rs1,
               ex_cond, ex_pred_taken, ex_pred_target,
        output pred_taken, pred_target, has_branched, mispredict, redirect_pc,
               stat_branches, stat_mispred
    );
endinterface

// File: rtl/branch_predict_unit_table.sv
// Direct-mapped BTB/BHT storage: one combinational read port for IF and one
// synchronous update port for EX that applies the counter/allocation rules.
module bpu_table #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 64,
    parameter int IDX_W = $clog2(DEPTH),
    parameter int TAG_W = XLEN - IDX_W - 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx,
    output bpu_pkg::btb_entry_t rd_meta,
    output logic [TAG_W-1:0] rd_tag,
    output logic [XLEN-1:0]  rd_target,
    input  logic             wr_en,
    input  bpu_pkg::brclass_e wr_class,
    input  logic             wr_taken,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic [XLEN-1:0]  wr_target
);
    import bpu_pkg::*;

    btb_entry_t       meta    [DEPTH];
    logic [TAG_W-1:0] tags    [DEPTH];
    logic [XLEN-1:0]  targets [DEPTH];

    logic wr_hit;
    logic wr_alloc;

    assign rd_meta   = meta[rd_idx];
    assign rd_tag    = tags[rd_idx];
    assign rd_target = targets[rd_idx];

    assign wr_hit   = meta[wr_idx].valid && (tags[wr_idx] == wr_tag);
    assign wr_alloc = wr_en && ((wr_class == CL_COND && wr_taken) ||
                                wr_class == CL_JAL || wr_class == CL_JALR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                meta[i] <= '{valid: 1'b0, ctr: CTR_RESET};
            end
        end else if (wr_en) begin
            case (wr_class)
                CL_COND: begin
                    if (wr_taken) begin
                        meta[wr_idx].valid <= 1'b1;
                        meta[wr_idx].ctr   <= wr_hit ? ctr_inc(meta[wr_idx].ctr)
                                                     : CTR_TAKEN_ALLOC;
                    end else begin
                        meta[wr_idx].ctr <= ctr_dec(meta[wr_idx].ctr);
                    end
                end
                CL_JAL, CL_JALR: meta[wr_idx] <= '{valid: 1'b1, ctr: CTR_JUMP};
                // A non-branch sitting at a predicted PC evicts the alias.
                default: if (wr_hit) meta[wr_idx].valid <= 1'b0;
            endcase
        end
    end

    // Tag/target are only meaningful while valid, so they need no reset.
    always_ff @(posedge clk) begin
        if (wr_alloc) begin
            tags[wr_idx]    <= wr_tag;
            targets[wr_idx] <= wr_target;
        end
    end

endmodule

// File: rtl/branch_predict_unit.sv
// Branch predict unit: BTB lookup for IF, control-flow resolve and mispredict
// detection for EX, table update and saturating statistics.
module branch_predict_unit #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 64,
    parameter int CNT_W = 32
) (
    input  logic clk,
    input  logic rst_n,
    bpu_if.slave bus
);
    import bpu_pkg::*;

    localparam int IDX_W = $clog2(DEPTH);
    localparam int TAG_W = XLEN - IDX_W - 2;

    btb_entry_t       rd_meta;
    logic [TAG_W-1:0] rd_tag;
    logic [XLEN-1:0]  rd_target;
    logic             hit;

    brclass_e         cls;
    logic             taken;
    logic [XLEN-1:0]  seq_pc;
    logic [XLEN-1:0]  target;
    logic [XLEN-1:0]  redirect;
    logic [XLEN-1:0]  predicted;
    logic             mispred;

    logic [CNT_W-1:0] stat_br_q;
    logic [CNT_W-1:0] stat_mp_q;

    bpu_table #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_table (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_idx    (bus.if_pc[IDX_W+1:2]),
        .rd_meta   (rd_meta),
        .rd_tag    (rd_tag),
        .rd_target (rd_target),
        .wr_en     (bus.ex_valid),
        .wr_class  (cls),
        .wr_taken  (taken),
        .wr_idx    (bus.ex_pc[IDX_W+1:2]),
        .wr_tag    (bus.ex_pc[XLEN-1:IDX_W+2]),
        .wr_target (target)
    );

    assign hit             = rd_meta.valid && (rd_tag == bus.if_pc[XLEN-1:IDX_W+2]);
    assign bus.pred_taken  = hit && rd_meta.ctr[1];
    assign bus.pred_target = hit ? rd_target : bus.if_pc + XLEN'(4);

    always_comb begin
        cls    = classify(bus.ex_brsel);
        seq_pc = bus.ex_pc + XLEN'(4);
        target = bus.ex_pc + bus.ex_immediate;
        taken  = 1'b0;
        case (cls)
            CL_COND: taken = bus.ex_cond;
            CL_JAL:  taken = 1'b1;
            CL_JALR: begin
                taken  = 1'b1;
                target = (bus.ex_rs1 + bus.ex_immediate) & {{(XLEN-1){1'b1}}, 1'b0};
            end
            default: taken = 1'b0;
        endcase
        redirect  = taken ? target : seq_pc;
        predicted = bus.ex_pred_taken ? bus.ex_pred_target : seq_pc;
        mispred   = bus.ex_valid && (redirect != predicted);
    end

    assign bus.has_branched = bus.ex_valid && taken;
    assign bus.mispredict   = mispred;
    assign bus.redirect_pc  = redirect;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_br_q <= '0;
            stat_mp_q <= '0;
        end else if (bus.ex_valid) begin
            if (cls != CL_NONE && stat_br_q != '1) stat_br_q <= stat_br_q + CNT_W'(1);
            if (mispred && stat_mp_q != '1)        stat_mp_q <= stat_mp_q + CNT_W'(1);
        end
    end

    assign bus.stat_branches = stat_br_q;
    assign bus.stat_mispred  = stat_mp_q;

endmodule
